// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] insn;
    } fetch_entry_t;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, insn} fetch entries with single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = cnt_w(DEPTH),
    localparam int AW = $clog2(DEPTH),
    localparam int EW = $bits(fetch_entry_t)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [EW-1:0] data_i,
    input  logic          pop_i,
    output logic [EW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; empty_o qualifies the head entry.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, credit-limited imem requests, response queue.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rdy,
    input  logic            i_imem_rsp_vld,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic            o_insn_vld,
    output logic [XLEN-1:0] o_insn,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_insn_rdy
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty, push, pop;
    logic            req_fire, rsp_drop, rsp_take, bypass;
    fetch_entry_t    push_entry, head_entry;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (i_redirect),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    assign credit_used = {1'b0, occ} + {1'b0, outst_q};
    assign o_imem_addr = fetch_pc_q;
    assign push_entry  = '{pc: rsp_pc_q, insn: i_imem_rsp_data};

    always_comb begin
        o_imem_req = !i_rst && !i_redirect && (credit_used < DEPTH_C);
        req_fire   = o_imem_req && i_imem_rdy;
        rsp_drop   = i_imem_rsp_vld && (drop_q != '0);
        // A response landing in a redirect cycle is stale and never delivered.
        rsp_take   = i_imem_rsp_vld && (drop_q == '0) && !i_redirect && !i_rst;
`ifdef FETCH_BYPASS_EN
        bypass     = rsp_take && fifo_empty && i_insn_rdy;
`else
        bypass     = 1'b0;
`endif
        push       = rsp_take && !bypass;
        pop        = !fifo_empty && i_insn_rdy && !i_redirect;

        fetch_pc_d = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d   = rsp_take ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(i_imem_rsp_vld);
        drop_d     = drop_q - CW'(rsp_drop);
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            rsp_pc_d   = i_redirect_pc;
            drop_d     = outst_q - CW'(i_imem_rsp_vld);
        end

        if (bypass) begin
            o_insn_vld = 1'b1;
            o_insn     = i_imem_rsp_data;
            o_pc       = rsp_pc_q;
        end else begin
            o_insn_vld = !fifo_empty;
            o_insn     = fifo_empty ? '0 : head_entry.insn;
            o_pc       = fifo_empty ? '0 : head_entry.pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // The credit rule reserves a slot for every in-flight response.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_redirect) begin
            assert (!(push && fifo_full && !pop));
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RV32I core family. It replaces the single PC register and direct instruction lookup with a real fetch stage:
- owns the fetch PC;
- issues in-order requests to an instruction memory with a valid/ready handshake and variable response latency;
- buffers returned instructions with their PCs in a DEPTH-entry queue;
- hands them to decode with a valid/ready handshake.

Control-flow redirects from execute flush the queue and discard stale in-flight responses.

## Interface
Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_redirect  in  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  XLEN  redirect target.
- o_imem_req  out  1  request valid.
- o_imem_addr  out  XLEN  request address (current fetch PC).
- i_imem_rdy  in  1  memory accepts the request.
- i_imem_rsp_vld  in  1  response valid; in order; cannot be back-pressured.
- i_imem_rsp_data  in  XLEN  instruction word.
- o_insn_vld  out  1  instruction available to decode.
- o_insn  out  XLEN  instruction word.
- o_pc  out  XLEN  PC of o_insn.
- i_insn_rdy  in  1  decode consumes the instruction.

## Operation
State:
- fetch_pc: next address to request.
- rsp_pc: PC of the next accepted response.
- outstanding counter: clog2(DEPTH+1) bits.
- drop counter: same width.
- queue: DEPTH entries of {pc, insn}.

Issue:
- o_imem_req = !i_rst && !i_redirect && (occupancy + outstanding < DEPTH).
- Request accepted when o_imem_req && i_imem_rdy: fetch_pc += 4, outstanding += 1.
- The credit rule guarantees every response has a free slot. Queue overflow is impossible and is asserted against.

Response:
- If drop counter > 0: the response is discarded, drop -= 1, outstanding -= 1.
- Otherwise: push {rsp_pc, data}, rsp_pc += 4, outstanding -= 1.

Dequeue:
- o_insn_vld = queue not empty.
- o_insn and o_pc come from the head entry.
- Pop on o_insn_vld && i_insn_rdy.
- Push and pop in the same cycle are both honoured.

Redirect, applied at the edge where i_redirect = 1:
- queue emptied;
- fetch_pc and rsp_pc load i_redirect_pc;
- drop counter loads the in-flight count excluding any response arriving that cycle; that response is discarded;
- pop in the redirect cycle is ignored (o_insn_vld still reflects the old head).
- Back-to-back redirects: the last one wins; the drop counter is recomputed each time.

Arithmetic:
- PC increments wrap modulo 2^XLEN.
- No alignment check on the redirect target; bits [1:0] pass through.

## Timing
- Reset values: o_imem_req = 0, o_imem_addr = RESET_PC, o_insn_vld = 0, o_insn = 0, o_pc = 0, all counters 0.
- First request in the cycle after i_rst deasserts.
- Minimum request-to-decode latency:
  - 1 cycle of memory latency plus 1 queue cycle without FETCH_BYPASS_EN;
  - memory latency only with it (see Configuration).
- After a redirect, the first request to the new PC is issued the next cycle.
- Reset mid-operation: all state cleared at that edge; responses arriving after reset are discarded only if the memory is also reset (memory requirement, outside this block).
- Sustained throughput is 1 instruction/cycle when memory latency < DEPTH cycles and decode is always ready.

## Configuration
FETCH_BYPASS_EN:
- Defined: when the queue is empty, a non-dropped response arrives and i_insn_rdy = 1, the response drives o_insn_vld/o_insn/o_pc combinationally in the same cycle and is not pushed.
- Undefined: every response goes through the queue, so o_insn_vld rises at the earliest one cycle after the response.

## Structure
- Package fetch_pkg holds:
  - XLEN default;
  - INSN_NOP = 32'h0000_0013;
  - typedef fetch_entry_t {pc, insn};
  - the counter-width function.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with a flush input, DEPTH parameter, and full/empty/occupancy outputs.
- Top level holds the PC, credit and drop logic plus the bypass mux.

## Test plan
- Reset release with RESET_PC = 0, 1-cycle memory, decode always ready -> requests to 0x0, 0x4, 0x8…; decode sees PCs 0x0, 0x4… one per cycle after pipeline fill.
- Decode stalled, DEPTH = 4 -> exactly 4 requests issued, then o_imem_req = 0; releasing i_insn_rdy yields 4 instructions in order, then fetch resumes.
- Redirect to 0x100 with 3 responses in flight -> next 3 responses are dropped, the first instruction delivered has o_pc = 0x100, queue empty the cycle after the redirect.
- Redirect in the same cycle as a response and a pop -> that response is not delivered, drop count equals the remaining in-flight requests, no duplicate or lost PC.
- Fetch PC at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
- FETCH_BYPASS_EN, empty queue, response at cycle N with decode ready -> o_insn_vld = 1 in cycle N; without the macro, in cycle N+1.
